// File: rtl/adxl362_pkg.sv
// Shared constants, state encodings and frame-content helper for the ADXL362 SPI reader.
package adxl362_pkg;

    localparam logic [7:0] CMD_WRITE     = 8'h0A;
    localparam logic [7:0] CMD_READ      = 8'h0B;
    localparam logic [7:0] REG_POWER_CTL = 8'h2D;
    localparam logic [7:0] REG_XDATA_L   = 8'h0E;

    localparam int INIT_BYTES = 3;
    localparam int READ_BYTES = 8;

    typedef enum logic [2:0] {
        POWERUP   = 3'd0,
        INIT_XFER = 3'd1,
        GAP       = 3'd2,
        READ_XFER = 3'd3,
        PUBLISH   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP = 2'd0,
        PH_SHIFT = 2'd1,
        PH_HOLD  = 2'd2
    } phase_t;

    // TX byte at position idx of the init-write or burst-read frame.
    function automatic logic [7:0] frame_byte(input logic is_init, input logic [2:0] idx,
                                              input logic [7:0] init_val);
        logic [7:0] b;
        b = 8'h00;
        if (is_init) begin
            case (idx)
                3'd0:    b = CMD_WRITE;
                3'd1:    b = REG_POWER_CTL;
                3'd2:    b = init_val;
                default: b = 8'h00;
            endcase
        end else begin
            case (idx)
                3'd0:    b = CMD_READ;
                3'd1:    b = REG_XDATA_L;
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/adxl362_spi_reader_shifter.sv
// Mode-0 single-byte SPI engine: one sclk edge per enabled tick, MSB first.
module spi_byte_shifter (
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic [7:0] rx_byte,
    output logic       byte_done,
    output logic       sclk,
    output logic       mosi
);

    logic [7:0] tx_sr_r;
    logic [7:0] rx_sr_r;
    logic [2:0] bit_cnt_r;
    logic       active_r;

    // Strobe on the tick that performs the eighth falling edge.
    assign byte_done = tick && active_r && sclk && (bit_cnt_r == 3'd7);
    assign rx_byte   = rx_sr_r;

    // Load presets bit 7 on mosi; rise ticks sample miso, fall ticks advance mosi.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            tx_sr_r   <= 8'h00;
            rx_sr_r   <= 8'h00;
            bit_cnt_r <= 3'd0;
            active_r  <= 1'b0;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
        end else if (load) begin
            tx_sr_r   <= tx_byte;
            bit_cnt_r <= 3'd0;
            active_r  <= 1'b1;
            sclk      <= 1'b0;
            mosi      <= tx_byte[7];
        end else if (tick && active_r) begin
            if (!sclk) begin
                sclk    <= 1'b1;
                rx_sr_r <= {rx_sr_r[6:0], miso};
            end else begin
                sclk <= 1'b0;
                if (bit_cnt_r == 3'd7) begin
                    active_r <= 1'b0;
                    mosi     <= 1'b0;
                end else begin
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                    tx_sr_r   <= {tx_sr_r[6:0], 1'b0};
                    mosi      <= tx_sr_r[6];
                end
            end
        end
    end

endmodule

// File: rtl/adxl362_spi_reader.sv
// ADXL362 front end: enables measurement mode once, then periodically burst-reads X/Y/Z
// over SPI mode 0, paced entirely by a half-SCLK tick strobe.
module adxl362_spi_reader
    import adxl362_pkg::*;
#(
    parameter int         GAP_TICKS      = 1000,
    parameter int         CS_SETUP_TICKS = 2,
    parameter logic [7:0] INIT_VAL       = 8'h02
) (
    input  logic               CLK100MHZ,
    input  logic               reset,
    input  logic               tick,
    input  logic               miso,
    output logic               sclk,
    output logic               mosi,
    output logic               cs_n,
    output logic signed [11:0] acc_x,
    output logic signed [11:0] acc_y,
    output logic signed [11:0] acc_z,
    output logic               data_valid,
    output logic               init_done
);

    localparam int               CNT_W      = $clog2(GAP_TICKS + 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP_TICKS - 1);
    localparam logic [2:0]       INIT_LAST  = 3'(INIT_BYTES - 1);
    localparam logic [2:0]       READ_LAST  = 3'(READ_BYTES - 1);

    state_t           state_r;
    phase_t           phase_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       byte_idx_r;
    logic [47:0]      rx_data_r;

    logic       in_xfer_s;
    logic       shift_tick_s;
    logic       load_s;
    logic [7:0] tx_byte_s;
    logic [2:0] last_idx_s;
    logic [7:0] rx_byte_s;
    logic       byte_done_s;

    assign in_xfer_s    = (state_r == INIT_XFER) || (state_r == READ_XFER);
    // The first rise lands on the last setup tick, so the shifter is enabled one tick early.
    assign shift_tick_s = tick && in_xfer_s &&
                          ((phase_r == PH_SHIFT) || ((phase_r == PH_SETUP) && (cnt_r == SETUP_LAST)));
    assign last_idx_s   = (state_r == INIT_XFER) ? INIT_LAST : READ_LAST;

    // Byte loads: first byte on frame entry, next byte on the previous byte's last fall.
    always_comb begin
        load_s    = 1'b0;
        tx_byte_s = 8'h00;
        case (state_r)
            POWERUP, GAP: begin
                if (tick && (cnt_r == GAP_LAST)) begin
                    load_s    = 1'b1;
                    tx_byte_s = frame_byte(state_r == POWERUP, 3'd0, INIT_VAL);
                end else begin
                    load_s = 1'b0;
                end
            end
            INIT_XFER, READ_XFER: begin
                if (byte_done_s && (byte_idx_r != last_idx_s)) begin
                    load_s    = 1'b1;
                    tx_byte_s = frame_byte(state_r == INIT_XFER, byte_idx_r + 3'd1, INIT_VAL);
                end else begin
                    load_s = 1'b0;
                end
            end
            default: load_s = 1'b0;
        endcase
    end

    spi_byte_shifter u_shifter (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .tick      (shift_tick_s),
        .load      (load_s),
        .tx_byte   (tx_byte_s),
        .miso      (miso),
        .rx_byte   (rx_byte_s),
        .byte_done (byte_done_s),
        .sclk      (sclk),
        .mosi      (mosi)
    );

    // Frame sequencing, chip select, sample capture and publication.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_r    <= POWERUP;
            phase_r    <= PH_SETUP;
            cnt_r      <= '0;
            byte_idx_r <= 3'd0;
            rx_data_r  <= 48'h0;
            cs_n       <= 1'b1;
            acc_x      <= 12'sd0;
            acc_y      <= 12'sd0;
            acc_z      <= 12'sd0;
            data_valid <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state_r)
                POWERUP, GAP: begin
                    if (tick) begin
                        if (cnt_r == GAP_LAST) begin
                            state_r    <= (state_r == POWERUP) ? INIT_XFER : READ_XFER;
                            phase_r    <= PH_SETUP;
                            cnt_r      <= '0;
                            byte_idx_r <= 3'd0;
                            cs_n       <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r + 1'b1;
                        end
                    end
                end
                INIT_XFER, READ_XFER: begin
                    if (tick) begin
                        case (phase_r)
                            PH_SETUP: begin
                                if (cnt_r == SETUP_LAST) begin
                                    phase_r <= PH_SHIFT;
                                    cnt_r   <= '0;
                                end else begin
                                    cnt_r <= cnt_r + 1'b1;
                                end
                            end
                            PH_SHIFT: begin
                                if (byte_done_s) begin
                                    // Bytes 0 and 1 fall out of the top of the 48-bit window.
                                    if (state_r == READ_XFER) begin
                                        rx_data_r <= {rx_data_r[39:0], rx_byte_s};
                                    end
                                    if (byte_idx_r == last_idx_s) begin
                                        phase_r <= PH_HOLD;
                                        cnt_r   <= '0;
                                    end else begin
                                        byte_idx_r <= byte_idx_r + 3'd1;
                                    end
                                end
                            end
                            PH_HOLD: begin
                                if (cnt_r == SETUP_LAST) begin
                                    cs_n  <= 1'b1;
                                    cnt_r <= '0;
                                    if (state_r == INIT_XFER) begin
                                        init_done <= 1'b1;
                                        state_r   <= GAP;
                                    end else begin
                                        state_r <= PUBLISH;
                                    end
                                end else begin
                                    cnt_r <= cnt_r + 1'b1;
                                end
                            end
                            default: phase_r <= PH_SETUP;
                        endcase
                    end
                end
                PUBLISH: begin
                    acc_x      <= $signed({rx_data_r[35:32], rx_data_r[47:40]});
                    acc_y      <= $signed({rx_data_r[19:16], rx_data_r[31:24]});
                    acc_z      <= $signed({rx_data_r[3:0],   rx_data_r[15:8]});
                    data_valid <= 1'b1;
                    state_r    <= GAP;
                    // A tick landing in this cycle already counts toward the gap.
                    cnt_r      <= {{(CNT_W-1){1'b0}}, tick};
                end
                default: state_r <= POWERUP;
            endcase
        end
    end

endmodule

// File: tb/tb_adxl362_spi_reader.sv
// Self-checking bench: behavioural ADXL362 slave plus scoreboard of frames and published samples.
module tb_adxl362_spi_reader;

    logic               CLK100MHZ;
    logic               reset;
    logic               tick;
    logic               miso;
    logic               sclk;
    logic               mosi;
    logic               cs_n;
    logic signed [11:0] acc_x;
    logic signed [11:0] acc_y;
    logic signed [11:0] acc_z;
    logic               data_valid;
    logic               init_done;

    int n_checks = 0;
    int n_errors = 0;
    int tick_period = 1;

    logic [47:0] next_resp;
    logic [47:0] cur_resp;
    int          frame_len_q[$];
    logic [63:0] frame_data_q[$];
    logic [47:0] sent_q[$];
    logic [35:0] dv_q[$];
    int          gap_q[$];
    int          rise_n = 0;
    int          dv_count = 0;
    int          mosi_unstable = 0;
    int          bad_period = 0;
    int          dv_wide = 0;
    int          sclk_at_cs_rise = 0;
    int          mosi_idle_bad = 0;

    adxl362_spi_reader #(.GAP_TICKS(20), .CS_SETUP_TICKS(2), .INIT_VAL(8'h02)) dut (
        .CLK100MHZ  (CLK100MHZ),
        .reset      (reset),
        .tick       (tick),
        .miso       (miso),
        .sclk       (sclk),
        .mosi       (mosi),
        .cs_n       (cs_n),
        .acc_x      (acc_x),
        .acc_y      (acc_y),
        .acc_z      (acc_z),
        .data_valid (data_valid),
        .init_done  (init_done)
    );

    initial begin
        CLK100MHZ = 1'b0;
        forever #5 CLK100MHZ = ~CLK100MHZ;
    end

    // Tick strobe, updated 2 ns after each rising edge.
    initial begin
        int ph;
        ph   = 0;
        tick = 1'b1;
        forever begin
            @(posedge CLK100MHZ);
            #2;
            ph   = (ph + 1 >= tick_period) ? 0 : ph + 1;
            tick = (ph == 0);
        end
    end

    function automatic logic miso_bit(input int n, input logic [47:0] resp);
        if (n >= 16 && n < 64) return resp[63 - n];
        return 1'b0;
    endfunction

    // Slave model and bus monitor, sampling at falling edges.
    initial begin
        logic        prev_cs_n, prev_sclk, prev_mosi, prev_dv, tick_prev, first_rise, gap_open;
        logic [63:0] fdata;
        int          ticks_since_rise, gap_cycles;
        prev_cs_n = 1'b1; prev_sclk = 1'b0; prev_mosi = 1'b0; prev_dv = 1'b0;
        tick_prev = 1'b0; first_rise = 1'b1; gap_open = 1'b0;
        fdata = 64'h0; ticks_since_rise = 0; gap_cycles = 0;
        miso = 1'b0;
        cur_resp = 48'h0;
        forever begin
            @(negedge CLK100MHZ);
            if (tick_prev) ticks_since_rise++;
            if (prev_cs_n && !cs_n) begin
                rise_n = 0; fdata = 64'h0; cur_resp = next_resp; first_rise = 1'b1;
                miso = miso_bit(0, cur_resp);
                if (gap_open) gap_q.push_back(gap_cycles);
                gap_open = 1'b0;
            end
            if (!cs_n && !prev_sclk && sclk) begin
                if (mosi !== prev_mosi) mosi_unstable++;
                if (!first_rise && ticks_since_rise != 2) bad_period++;
                first_rise = 1'b0;
                ticks_since_rise = 0;
                fdata = {fdata[62:0], mosi};
                rise_n++;
            end
            if (!cs_n && prev_sclk && !sclk) miso = miso_bit(rise_n, cur_resp);
            if (!prev_cs_n && cs_n) begin
                frame_len_q.push_back(rise_n);
                frame_data_q.push_back(fdata);
                if (rise_n == 64 && fdata[63:56] == 8'h0B) sent_q.push_back(cur_resp);
                if (sclk !== 1'b0) sclk_at_cs_rise++;
                miso = 1'b0;
                gap_open = 1'b1;
                gap_cycles = 1;
            end else if (cs_n && gap_open) begin
                gap_cycles++;
            end
            if (cs_n && mosi !== 1'b0) mosi_idle_bad++;
            if (data_valid) begin
                dv_q.push_back({acc_x, acc_y, acc_z});
                dv_count++;
                if (prev_dv) dv_wide++;
            end
            prev_cs_n = cs_n; prev_sclk = sclk; prev_mosi = mosi;
            prev_dv = data_valid; tick_prev = tick;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_dv(input int k, input int limit);
        int i;
        i = 0;
        while (dv_count < k && i < limit) begin
            @(negedge CLK100MHZ);
            i++;
        end
        check("dv_timeout", 64'(dv_count >= k), 64'd1);
    endtask

    task automatic wait_frames(input int k, input int limit);
        int i;
        i = 0;
        while (frame_len_q.size() < k && i < limit) begin
            @(negedge CLK100MHZ);
            i++;
        end
        check("frame_timeout", 64'(frame_len_q.size() >= k), 64'd1);
    endtask

    // Expected published samples: 12-bit two's complement from low byte plus high nibble.
    function automatic logic [35:0] model_acc(input logic [47:0] p);
        int v[3];
        for (int a = 0; a < 3; a++) begin
            int lo, hi;
            lo = int'(p[47 - 16*a -: 8]);
            hi = int'(p[39 - 16*a -: 8]);
            v[a] = (hi % 16) * 256 + lo;
            if (v[a] > 2047) v[a] = v[a] - 4096;
        end
        return {12'(v[0]), 12'(v[1]), 12'(v[2])};
    endfunction

    initial begin
        int t, i, fc, dvc;
        reset     = 1'b1;
        next_resp = 48'h34_02_FF_FF_00_08;

        @(posedge CLK100MHZ);
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK100MHZ);
            check("reset_idle", 64'({cs_n, sclk, mosi, data_valid, init_done, acc_x, acc_y, acc_z}),
                  64'({1'b1, 4'b0000, 36'h0}));
        end
        reset = 1'b0;

        t = 0; i = 0;
        while (cs_n && i < 500) begin
            @(posedge CLK100MHZ);
            if (tick) t++;
            #1;
            i++;
        end
        check("first_cs_fall_ticks", 64'(t), 64'd20);
        check("init_done_during_init", 64'(init_done), 64'd0);

        wait_frames(1, 2000);
        check("init_len", 64'(frame_len_q[0]), 64'd24);
        check("init_bytes", frame_data_q[0], 64'h0A2D02);
        @(negedge CLK100MHZ);
        check("init_done_after", 64'(init_done), 64'd1);

        wait_dv(1, 4000);
        wait_frames(2, 100);
        check("read_len", 64'(frame_len_q[1]), 64'd64);
        check("read_bytes", frame_data_q[1], 64'h0B0E_0000_0000_0000);
        check("fixed_acc_x", 64'(dv_q[0][35:24]), 64'h234);
        check("fixed_acc_y", 64'(dv_q[0][23:12]), 64'hFFF);
        check("fixed_acc_z", 64'(dv_q[0][11:0]), 64'h800);

        for (int k = 2; k <= 4; k++) begin
            next_resp = {16'($urandom), 32'($urandom)};
            wait_dv(k, 4000);
        end
        check("gap_count", 64'(gap_q.size() >= 4), 64'd1);
        foreach (gap_q[g]) check("gap_ticks", 64'(gap_q[g]), 64'd20);

        next_resp   = 48'h34_02_FF_FF_00_08;
        tick_period = 7;
        wait_dv(5, 5000);
        check("slow_acc", 64'(dv_q[4]), 64'(36'h234_FFF_800));

        tick_period = 1;
        i = 0;
        while (!(cs_n == 1'b0 && rise_n >= 35) && i < 3000) begin
            @(negedge CLK100MHZ);
            i++;
        end
        check("mid_read_reached", 64'(rise_n >= 35), 64'd1);
        dvc   = dv_count;
        reset = 1'b1;
        @(posedge CLK100MHZ);
        #1;
        check("abort_cs_sclk", 64'({cs_n, sclk}), 64'b10);
        check("abort_acc", 64'({acc_x, acc_y, acc_z}), 64'h0);
        check("abort_init_done", 64'(init_done), 64'd0);
        repeat (2) @(negedge CLK100MHZ);
        reset = 1'b0;
        fc = frame_len_q.size();
        wait_frames(fc + 1, 2000);
        check("post_reset_len", 64'(frame_len_q[fc]), 64'd24);
        check("post_reset_bytes", frame_data_q[fc], 64'h0A2D02);
        check("abort_no_publish", 64'(dv_count), 64'(dvc));

        check("score_count", 64'(dv_q.size()), 64'(sent_q.size()));
        for (int k = 0; k < dv_q.size() && k < sent_q.size(); k++)
            check("model_acc", 64'(dv_q[k]), 64'(model_acc(sent_q[k])));
        check("mosi_stable_at_rise", 64'(mosi_unstable), 64'd0);
        check("sclk_period_2_ticks", 64'(bad_period), 64'd0);
        check("dv_one_cycle", 64'(dv_wide), 64'd0);
        check("sclk_low_at_cs_rise", 64'(sclk_at_cs_rise), 64'd0);
        check("mosi_low_when_idle", 64'(mosi_idle_bad), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
